commit_trace_buffer: RTL and testbench

Downstream consumer of the core's commit port. Captures every retired instruction reported by `commit`/`commit_pc`/`commit_pre_pc`, stamps it with a sequence number and a control-flow-break flag, and buffers it in a small FIFO. A valid/ready trace port drains the FIFO for the simulation host or difftest checker. The block also keeps a 64-bit retired-instruction counter, a saturating drop counter, and a hang watchdog that flags a core that has stopped committing.

---
 rtl/commit_trace_buffer_if.sv | 25 ++
 rtl/commit_trace_buffer.sv | 84 ++++++++
 tb/tb_commit_trace_buffer.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/commit_trace_buffer_if.sv
// Commit-port and trace-port bundle for commit_trace_buffer.
// The slave side is the buffer; the master side is the core plus trace consumer.
interface commit_trace_buffer_if #(
  parameter int XLEN = 32
);
  logic            commit;
  logic [XLEN-1:0] commit_pc;
  logic [XLEN-1:0] commit_pre_pc;
  logic            trace_valid;
  logic            trace_ready;
  logic [XLEN-1:0] trace_pc;
  logic [XLEN-1:0] trace_pre_pc;
  logic [31:0]     trace_seq;
  logic            trace_jump;

  modport master (
    output commit, commit_pc, commit_pre_pc, trace_ready,
    input  trace_valid, trace_pc, trace_pre_pc, trace_seq, trace_jump
  );

  modport slave (
    input  commit, commit_pc, commit_pre_pc, trace_ready,
    output trace_valid, trace_pc, trace_pre_pc, trace_seq, trace_jump
  );
endinterface

// File: rtl/commit_trace_buffer.sv
// Captures retired instructions into a first-word-fall-through FIFO with sequence
// stamps, plus instret / drop counters and a commit-stall watchdog.
module commit_trace_buffer #(
  parameter int XLEN        = 32,
  parameter int DEPTH       = 8,
  parameter int HANG_CYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  commit_trace_buffer_if.slave     tif,
  output logic [63:0]              instret,
  output logic [15:0]              drop_cnt,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     hang
);
  localparam int AW = $clog2(DEPTH);
  localparam int IW = $clog2(HANG_CYCLES + 1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pre_pc;
    logic [31:0]     seq;
    logic            jump;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          head;
  entry_t          wr_ent;
  logic [AW:0]     wr_ptr, rd_ptr;
  logic [31:0]     seq_cnt;
  logic [IW-1:0]   idle_cnt;
  logic            full, empty, push, pop, drop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = !empty && tif.trace_ready;
  // A full FIFO still accepts a commit when the head leaves in the same cycle.
  assign push  = tif.commit && (!full || pop);
  assign drop  = tif.commit && full && !pop;

  always_comb begin
    wr_ent        = '0;
    wr_ent.pc     = tif.commit_pc;
    wr_ent.pre_pc = tif.commit_pre_pc;
    wr_ent.seq    = seq_cnt;
    wr_ent.jump   = (tif.commit_pc != (tif.commit_pre_pc + XLEN'(4)));
  end

  // Storage is not reset; the head is masked while empty, so stale slots never show.
  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr[AW-1:0]] <= wr_ent;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      seq_cnt  <= '0;
      instret  <= '0;
      drop_cnt <= '0;
      idle_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (tif.commit) begin
        seq_cnt  <= seq_cnt + 32'd1;
        instret  <= instret + 64'd1;
        idle_cnt <= '0;
      end else if (idle_cnt != IW'(HANG_CYCLES)) begin
        idle_cnt <= idle_cnt + 1'b1;
      end
      if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  assign head             = mem[rd_ptr[AW-1:0]];
  assign tif.trace_valid  = !empty;
  assign tif.trace_pc     = empty ? '0 : head.pc;
  assign tif.trace_pre_pc = empty ? '0 : head.pre_pc;
  assign tif.trace_seq    = empty ? '0 : head.seq;
  assign tif.trace_jump   = !empty && head.jump;
  assign fifo_level       = wr_ptr - rd_ptr;
  assign hang             = (idle_cnt == IW'(HANG_CYCLES));
endmodule

// File: tb/tb_commit_trace_buffer.sv
// Scoreboard bench for commit_trace_buffer: table vectors plus hand sequences
// for fill/drop, full streaming with wrap, watchdog, mid-run reset and random traffic.
module tb_commit_trace_buffer;
  localparam int XLEN  = 32;
  localparam int DEPTH = 8;
  localparam int HANG  = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] instret;
  logic [15:0] drop_cnt;
  logic [3:0]  fifo_level;
  logic        hang;

  always #5 clk = ~clk;

  commit_trace_buffer_if #(.XLEN(XLEN)) tif ();

  commit_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .HANG_CYCLES(HANG)) dut (
    .clk        (clk),
    .rst        (rst),
    .tif        (tif.slave),
    .instret    (instret),
    .drop_cnt   (drop_cnt),
    .fifo_level (fifo_level),
    .hang       (hang)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pre_pc;
    logic [31:0] seq;
    logic        jump;
  } ent_t;

  typedef struct {
    logic        c;
    logic [31:0] pc;
    logic [31:0] pre;
    logic        rdy;
    logic        jmp;
    int          lvl;
    longint      ir;
  } vec_t;

  ent_t        sb[$];
  vec_t        tbl[7];
  int          n_checks = 0;
  int          n_fail   = 0;
  longint      m_instret;
  int          m_drop;
  int          m_idle;
  logic [31:0] m_seq;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: check head/pop before the edge, update the model, check counters after.
  task automatic step(input logic c, input logic [31:0] pc, input logic [31:0] pre,
                      input logic rdy, input logic jmp);
    ent_t e;
    @(negedge clk);
    tif.commit = c; tif.commit_pc = pc; tif.commit_pre_pc = pre; tif.trace_ready = rdy;
    #1;
    chk("trace_valid", 64'(tif.trace_valid), 64'(sb.size() != 0));
    if (rdy && sb.size() != 0) begin
      e = sb.pop_front();
      chk("trace_pc", 64'(tif.trace_pc), 64'(e.pc));
      chk("trace_pre_pc", 64'(tif.trace_pre_pc), 64'(e.pre_pc));
      chk("trace_seq", 64'(tif.trace_seq), 64'(e.seq));
      chk("trace_jump", 64'(tif.trace_jump), 64'(e.jump));
    end
    if (c) begin
      if (sb.size() < DEPTH) begin
        e.pc = pc; e.pre_pc = pre; e.seq = m_seq; e.jump = jmp;
        sb.push_back(e);
      end else if (m_drop < 65535) begin
        m_drop++;
      end
      m_seq++;
      m_instret++;
      m_idle = 0;
    end else if (m_idle < HANG) begin
      m_idle++;
    end
    @(posedge clk); #1;
    chk("fifo_level", 64'(fifo_level), 64'(sb.size()));
    chk("instret", instret, m_instret);
    chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    chk("hang", 64'(hang), 64'(m_idle == HANG));
  endtask

  task automatic step_auto(input logic c, input logic [31:0] pc, input logic [31:0] pre,
                           input logic rdy);
    step(c, pc, pre, rdy, pc != pre + 32'd4);
  endtask

  task automatic do_reset(input logic c);
    @(negedge clk);
    rst = 1'b1; tif.commit = c; tif.commit_pc = 32'h1234_5678;
    tif.commit_pre_pc = 32'h0; tif.trace_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; tif.commit = 1'b0;
    chk("rst_valid", 64'(tif.trace_valid), 64'd0);
    chk("rst_pc", 64'(tif.trace_pc), 64'd0);
    chk("rst_pre_pc", 64'(tif.trace_pre_pc), 64'd0);
    chk("rst_seq", 64'(tif.trace_seq), 64'd0);
    chk("rst_jump", 64'(tif.trace_jump), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_instret", instret, 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    chk("rst_hang", 64'(hang), 64'd0);
    sb.delete();
    m_instret = 0; m_drop = 0; m_idle = 0; m_seq = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] pc, prev;
    rst = 1'b1; tif.commit = 1'b0; tif.commit_pc = '0; tif.commit_pre_pc = '0;
    tif.trace_ready = 1'b0;
    m_instret = 0; m_drop = 0; m_idle = 0; m_seq = '0;

    // Sequential PCs, a taken jump and an address-space wrap, drained as they arrive.
    tbl[0] = '{1'b1, 32'h8000_0000, 32'h7FFF_FFFC, 1'b1, 1'b0, 1, 1};
    tbl[1] = '{1'b1, 32'h8000_0004, 32'h8000_0000, 1'b1, 1'b0, 1, 2};
    tbl[2] = '{1'b1, 32'h8000_0008, 32'h8000_0004, 1'b1, 1'b0, 1, 3};
    tbl[3] = '{1'b0, 32'h0,         32'h0,         1'b1, 1'b0, 0, 3};
    tbl[4] = '{1'b1, 32'h8000_0100, 32'h8000_0008, 1'b1, 1'b1, 1, 4};
    tbl[5] = '{1'b1, 32'h0000_0000, 32'hFFFF_FFFC, 1'b1, 1'b0, 1, 5};
    tbl[6] = '{1'b0, 32'h0,         32'h0,         1'b1, 1'b0, 0, 5};

    do_reset(1'b0);
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].c, tbl[i].pc, tbl[i].pre, tbl[i].rdy, tbl[i].jmp);
      chk("tbl_level", 64'(fifo_level), 64'(tbl[i].lvl));
      chk("tbl_instret", instret, 64'(tbl[i].ir));
    end

    // Fill with the consumer stalled: 8 kept, 2 dropped.
    do_reset(1'b0);
    pc = 32'h8000_0000;
    for (int i = 0; i < 10; i++) begin
      step_auto(1'b1, pc, pc - 32'd4, 1'b0);
      pc += 32'd4;
    end
    chk("fill_level", 64'(fifo_level), 64'd8);
    chk("fill_drop", 64'(drop_cnt), 64'd2);
    chk("fill_instret", instret, 64'd10);

    // Full-FIFO streaming: push+pop every cycle, both pointers wrap several times.
    for (int i = 0; i < 24; i++) begin
      step_auto(1'b1, pc, pc - 32'd4, 1'b1);
      pc += 32'd4;
    end
    chk("stream_level", 64'(fifo_level), 64'd8);
    chk("stream_drop", 64'(drop_cnt), 64'd2);
    for (int i = 0; i < 8; i++) step_auto(1'b0, 32'h0, 32'h0, 1'b1);
    chk("drain_level", 64'(fifo_level), 64'd0);

    // Watchdog trips on the 16th idle cycle and restarts after a commit.
    do_reset(1'b0);
    for (int i = 0; i < HANG - 1; i++) step_auto(1'b0, 32'h0, 32'h0, 1'b1);
    chk("hang_early", 64'(hang), 64'd0);
    step_auto(1'b0, 32'h0, 32'h0, 1'b1);
    chk("hang_trip", 64'(hang), 64'd1);
    step_auto(1'b1, 32'h100, 32'h0FC, 1'b1);
    chk("hang_clear", 64'(hang), 64'd0);
    for (int i = 0; i < HANG - 1; i++) step_auto(1'b0, 32'h0, 32'h0, 1'b1);
    chk("hang_restart", 64'(hang), 64'd0);
    step_auto(1'b0, 32'h0, 32'h0, 1'b1);
    chk("hang_retrip", 64'(hang), 64'd1);

    // Mid-run reset with 5 queued, 3 dropped and hang raised.
    do_reset(1'b0);
    pc = 32'h2000_0000;
    for (int i = 0; i < 11; i++) begin
      step_auto(1'b1, pc, pc - 32'd4, 1'b0);
      pc += 32'd4;
    end
    for (int i = 0; i < 3; i++)  step_auto(1'b0, 32'h0, 32'h0, 1'b1);
    for (int i = 0; i < 13; i++) step_auto(1'b0, 32'h0, 32'h0, 1'b0);
    chk("pre_rst_level", 64'(fifo_level), 64'd5);
    chk("pre_rst_drop", 64'(drop_cnt), 64'd3);
    chk("pre_rst_hang", 64'(hang), 64'd1);
    do_reset(1'b1);
    step_auto(1'b0, 32'h0, 32'h0, 1'b1);
    chk("post_rst_instret", instret, 64'd0);

    // Random traffic against the scoreboard.
    do_reset(1'b0);
    prev = 32'h8000_0000;
    for (int i = 0; i < 300; i++) begin
      pc = ($urandom_range(0, 3) == 0) ? $urandom() : prev + 32'd4;
      if ($urandom_range(0, 2) != 0) begin
        step_auto(1'b1, pc, prev, $urandom_range(0, 3) != 0);
        prev = pc;
      end else begin
        step_auto(1'b0, 32'h0, 32'h0, $urandom_range(0, 3) != 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
